mem_access_ctrl: RTL and testbench

Multicycle sequencer for every load/store executed by the CPU MEM stage. It latches the access request, computes the byte-enable lanes and the store data lanes, and runs the req/ack handshake with data memory. For loads it drives the existing load data extender (opcode, be, raw word) and registers the extended result. Misaligned addresses and memory timeouts are reported as one-cycle fault pulses to the control unit.

---
 rtl/mem_access_ctrl_pkg.sv | 43 ++++
 rtl/mem_access_ctrl_if.sv | 26 ++
 rtl/mem_access_ctrl_be_gen.sv | 36 +++
 rtl/mem_access_ctrl.sv | 174 +++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage access sequencer: widths, load/store
// opcodes (instruction[31:26]), FSM state encoding, lane payload struct and
// opcode classification helpers.
package mem_access_ctrl_pkg;

  localparam int unsigned DW  = 32;
  localparam int unsigned OPW = 6;
  localparam int unsigned BEW = 4;

  localparam logic [OPW-1:0] O_LB  = 6'h20;
  localparam logic [OPW-1:0] O_LH  = 6'h21;
  localparam logic [OPW-1:0] O_LW  = 6'h23;
  localparam logic [OPW-1:0] O_LBU = 6'h24;
  localparam logic [OPW-1:0] O_LHU = 6'h25;
  localparam logic [OPW-1:0] O_SB  = 6'h28;
  localparam logic [OPW-1:0] O_SH  = 6'h29;
  localparam logic [OPW-1:0] O_SW  = 6'h2B;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_EXT   = 3'd2,
    S_DONE  = 3'd3,
    S_FAULT = 3'd4
  } state_e;

  // Byte lanes, lane-replicated store data and alignment verdict for one access
  typedef struct packed {
    logic [BEW-1:0] be;
    logic [DW-1:0]  wdata;
    logic           misaligned;
  } lane_t;

  function automatic logic is_load(input logic [OPW-1:0] op);
    return (op == O_LB) || (op == O_LH) || (op == O_LW) ||
           (op == O_LBU) || (op == O_LHU);
  endfunction

  function automatic logic is_store(input logic [OPW-1:0] op);
    return (op == O_SB) || (op == O_SH) || (op == O_SW);
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Data-memory request/acknowledge bus.
//   master (sequencer): drives mem_req, mem_we, mem_addr, mem_be, mem_wdata
//   slave  (memory)   : drives mem_rdata, mem_ack
interface mem_access_ctrl_if
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned AW = 32
);
  logic           mem_req;
  logic           mem_we;
  logic [AW-1:0]  mem_addr;
  logic [BEW-1:0] mem_be;
  logic [DW-1:0]  mem_wdata;
  logic [DW-1:0]  mem_rdata;
  logic           mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_access_ctrl_be_gen.sv
// Combinational lane generator.
//   i_opcode  : load/store opcode
//   i_addr_lo : byte offset within the word
//   i_wdata   : store source register
//   o_lane_c  : byte enables, replicated store data, misalignment flag
module mem_access_ctrl_be_gen
  import mem_access_ctrl_pkg::*;
(
  input  logic [OPW-1:0] i_opcode,
  input  logic [1:0]     i_addr_lo,
  input  logic [DW-1:0]  i_wdata,
  output lane_t          o_lane_c
);

  always_comb begin
    o_lane_c = '0;
    case (i_opcode)
      O_LB, O_LBU, O_SB: begin
        o_lane_c.be    = BEW'(4'b0001 << i_addr_lo);
        o_lane_c.wdata = {4{i_wdata[7:0]}};
      end
      O_LH, O_LHU, O_SH: begin
        o_lane_c.be         = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_lane_c.wdata      = {2{i_wdata[15:0]}};
        o_lane_c.misaligned = i_addr_lo[0];
      end
      O_LW, O_SW: begin
        o_lane_c.be         = 4'b1111;
        o_lane_c.wdata      = i_wdata;
        o_lane_c.misaligned = |i_addr_lo;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer: latches a request, runs the req/ack
// handshake, routes the raw load word through the external extender and
// reports completion / address errors / bus timeouts as one-cycle pulses.
//   clk, rst_n       : clock, async active-low reset
//   i_start          : request strobe (accepted only in IDLE)
//   i_opcode/i_addr/i_wdata : access description
//   mem              : data-memory bus (master side)
//   o_ext_* / i_ext_dout : load data extender hookup
//   o_ld_data        : extended load result, held until next load
//   o_busy, o_done, o_adel, o_ades, o_buserr : status to control unit
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned AW      = 32
)(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic [OPW-1:0]      i_opcode,
  input  logic [AW-1:0]       i_addr,
  input  logic [DW-1:0]       i_wdata,
  mem_access_ctrl_if.master   mem,
  output logic [OPW-1:0]      o_ext_opcode,
  output logic [BEW-1:0]      o_ext_be,
  output logic [DW-1:0]       o_ext_din,
  input  logic [DW-1:0]       i_ext_dout,
  output logic [DW-1:0]       o_ld_data,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_adel,
  output logic                o_ades,
  output logic                o_buserr
);

  localparam int unsigned CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam bit          TO_EN    = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  lane_t            w_lane;
  logic             w_launch, w_adel_nxt, w_ades_nxt, w_buserr_nxt;

  logic             r_is_load;
  logic             r_mem_req, r_mem_we;
  logic [AW-1:0]    r_mem_addr;
  logic [BEW-1:0]   r_mem_be;
  logic [DW-1:0]    r_mem_wdata;
  logic [OPW-1:0]   r_ext_opcode;
  logic [BEW-1:0]   r_ext_be;
  logic [DW-1:0]    r_ext_din, r_ld_data;
  logic             r_busy, r_done, r_adel, r_ades, r_buserr;

  mem_access_ctrl_be_gen u_be_gen (
    .i_opcode  (i_opcode),
    .i_addr_lo (i_addr[1:0]),
    .i_wdata   (i_wdata),
    .o_lane_c  (w_lane)
  );

  // State and timeout counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state, launch and fault-cause decode
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_launch     = 1'b0;
    w_adel_nxt   = 1'b0;
    w_ades_nxt   = 1'b0;
    w_buserr_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start && (is_load(i_opcode) || is_store(i_opcode))) begin
          w_cnt_nxt = '0;
          if (w_lane.misaligned) begin
            w_state_nxt = S_FAULT;
            w_adel_nxt  = is_load(i_opcode);
            w_ades_nxt  = is_store(i_opcode);
          end else begin
            w_state_nxt = S_REQ;
            w_launch    = 1'b1;
          end
        end
      end
      S_REQ: begin
        // An ack arriving on the expiry cycle still completes the access
        if (mem.mem_ack) begin
          w_state_nxt = r_is_load ? S_EXT : S_DONE;
        end else if (TO_EN && (r_cnt == CNT_LAST)) begin
          w_state_nxt  = S_FAULT;
          w_buserr_nxt = 1'b1;
        end else if (TO_EN) begin
          w_cnt_nxt = CNT_W'(r_cnt + 1'b1);
        end
      end
      S_EXT:   w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      S_FAULT: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Registered outputs and access datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_is_load    <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_be     <= '0;
      r_mem_wdata  <= '0;
      r_ext_opcode <= '0;
      r_ext_be     <= '0;
      r_ext_din    <= '0;
      r_ld_data    <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_adel       <= 1'b0;
      r_ades       <= 1'b0;
      r_buserr     <= 1'b0;
    end else begin
      r_mem_req <= (w_state_nxt == S_REQ);
      r_busy    <= (w_state_nxt != S_IDLE);
      r_done    <= (w_state_nxt == S_DONE) || (w_state_nxt == S_FAULT);
      r_adel    <= w_adel_nxt;
      r_ades    <= w_ades_nxt;
      r_buserr  <= w_buserr_nxt;
      if (w_launch) begin
        r_is_load   <= is_load(i_opcode);
        r_mem_we    <= is_store(i_opcode);
        r_mem_addr  <= {i_addr[AW-1:2], 2'b00};
        r_mem_be    <= w_lane.be;
        r_mem_wdata <= w_lane.wdata;
        // Extender controls only move on loads so ld_data stays coherent
        if (is_load(i_opcode)) begin
          r_ext_opcode <= i_opcode;
          r_ext_be     <= w_lane.be;
        end
      end
      if ((r_state == S_REQ) && mem.mem_ack && r_is_load) begin
        r_ext_din <= mem.mem_rdata;
      end
      if (r_state == S_EXT) begin
        r_ld_data <= i_ext_dout;
      end
    end
  end

  assign mem.mem_req   = r_mem_req;
  assign mem.mem_we    = r_mem_we;
  assign mem.mem_addr  = r_mem_addr;
  assign mem.mem_be    = r_mem_be;
  assign mem.mem_wdata = r_mem_wdata;
  assign o_ext_opcode  = r_ext_opcode;
  assign o_ext_be      = r_ext_be;
  assign o_ext_din     = r_ext_din;
  assign o_ld_data     = r_ld_data;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_adel        = r_adel;
  assign o_ades        = r_ades;
  assign o_buserr      = r_buserr;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: the driver queues expected memory
// requests and completions; a memory responder and a done monitor pop and
// compare them independently.
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [5:0]  opcode;
  logic [31:0] addr, wdata;
  logic [5:0]  ext_opcode;
  logic [3:0]  ext_be;
  logic [31:0] ext_din, ext_dout, ld_data;
  logic        busy, done, adel, ades, buserr;

  mem_access_ctrl_if #(.AW(32)) mem_if ();

  mem_access_ctrl #(.TIMEOUT(4), .AW(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (start),
    .i_opcode     (opcode),
    .i_addr       (addr),
    .i_wdata      (wdata),
    .mem          (mem_if),
    .o_ext_opcode (ext_opcode),
    .o_ext_be     (ext_be),
    .o_ext_din    (ext_din),
    .i_ext_dout   (ext_dout),
    .o_ld_data    (ld_data),
    .o_busy       (busy),
    .o_done       (done),
    .o_adel       (adel),
    .o_ades       (ades),
    .o_buserr     (buserr)
  );

  always #5 clk = ~clk;

  // Load data extender model
  logic [7:0]  ex_b;
  logic [15:0] ex_h;
  always_comb begin
    ex_b = ext_be[3] ? ext_din[31:24] : ext_be[2] ? ext_din[23:16] :
           ext_be[1] ? ext_din[15:8]  : ext_din[7:0];
    ex_h = ext_be[2] ? ext_din[31:16] : ext_din[15:0];
    ext_dout = ext_din;
    case (ext_opcode)
      O_LB:    ext_dout = {{24{ex_b[7]}}, ex_b};
      O_LBU:   ext_dout = {24'h0, ex_b};
      O_LH:    ext_dout = {{16{ex_h[15]}}, ex_h};
      O_LHU:   ext_dout = {16'h0, ex_h};
      default: ext_dout = ext_din;
    endcase
  end

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    int          delay;
    bit          noack;
    logic [31:0] rdata;
    int          req_cycles;
  } mem_exp_t;

  typedef struct {
    int          lat;
    logic        adel, ades, buserr;
    logic [31:0] ld;
  } done_exp_t;

  mem_exp_t  mq[$];
  done_exp_t dq[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic mem_exp_t mk_mem(input logic [31:0] a, input logic [3:0] be,
      input logic we, input logic [31:0] wd, input int dly, input bit na,
      input logic [31:0] rd, input int rc);
    mem_exp_t m;
    m.addr = a; m.be = be; m.we = we; m.wdata = wd; m.delay = dly;
    m.noack = na; m.rdata = rd; m.req_cycles = rc;
    return m;
  endfunction

  function automatic done_exp_t mk_done(input int lat, input logic el,
      input logic es, input logic eb, input logic [31:0] ld);
    done_exp_t d;
    d.lat = lat; d.adel = el; d.ades = es; d.buserr = eb; d.ld = ld;
    return d;
  endfunction

  // Memory responder: checks each new request, acks after the queued delay
  initial begin : responder
    mem_exp_t cur;
    bit active;
    int ncyc, waited;
    active = 0; ncyc = 0; waited = 0;
    cur = mk_mem(0, 0, 0, 0, 0, 1, 0, 0);
    mem_if.mem_ack = 1'b0;
    mem_if.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!active && mem_if.mem_req) begin
        active = 1; ncyc = 0; waited = 0;
        if (mq.size() == 0) begin
          chk("unexpected_req", 32'(mem_if.mem_req), 32'd0);
          cur = mk_mem(0, 0, 0, 0, 0, 1, 0, -1);
        end else begin
          cur = mq.pop_front();
          chk("mem_addr", mem_if.mem_addr, cur.addr);
          chk("mem_be", 32'(mem_if.mem_be), 32'(cur.be));
          chk("mem_we", 32'(mem_if.mem_we), 32'(cur.we));
          if (cur.we) chk("mem_wdata", mem_if.mem_wdata, cur.wdata);
        end
      end
      if (active) begin
        if (mem_if.mem_req) begin
          ncyc++;
          if (!mem_if.mem_ack && !cur.noack && waited == cur.delay) begin
            mem_if.mem_ack = 1'b1;
            mem_if.mem_rdata = cur.rdata;
          end else if (!mem_if.mem_ack) begin
            waited++;
          end
        end else begin
          active = 0;
          mem_if.mem_ack = 1'b0;
          chk("req_cycles", 32'(ncyc), 32'(cur.req_cycles));
        end
      end
    end
  end

  // Completion monitor
  initial begin : done_mon
    done_exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (dq.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'd0);
        end else begin
          e = dq.pop_front();
          chk("done_latency", 32'(cyc - start_cyc), 32'(e.lat));
          chk("adel", 32'(adel), 32'(e.adel));
          chk("ades", 32'(ades), 32'(e.ades));
          chk("buserr", 32'(buserr), 32'(e.buserr));
          chk("ld_data", ld_data, e.ld);
        end
      end
    end
  end

  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd);
    @(posedge clk); #1;
    start = 1'b1; opcode = op; addr = a; wdata = wd;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      if (!busy && !done) break;
      n++;
    end
    if (n >= 50) chk("idle_timeout", 32'(n), 32'd0);
  endtask

  task automatic run(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
      input bit has_mem, input mem_exp_t m, input done_exp_t d);
    if (has_mem) mq.push_back(m);
    dq.push_back(d);
    issue(op, a, wd);
    wait_idle();
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    mem_exp_t nomem;
    nomem = mk_mem(0, 0, 0, 0, 0, 1, 0, 0);
    rst_n = 1'b0; start = 1'b0; opcode = '0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_mem_req", 32'(mem_if.mem_req), 32'd0);
    chk("rst_ld_data", ld_data, 32'd0);
    chk("rst_mem_be", 32'(mem_if.mem_be), 32'd0);
    rst_n = 1'b1;

    run(O_LW,  32'h100, 32'h0, 1, mk_mem(32'h100, 4'hF, 0, 0, 0, 0, 32'hDEADBEEF, 1),
        mk_done(3, 0, 0, 0, 32'hDEADBEEF));
    run(O_LB,  32'h103, 32'h0, 1, mk_mem(32'h100, 4'h8, 0, 0, 0, 0, 32'h80112233, 1),
        mk_done(3, 0, 0, 0, 32'hFFFFFF80));
    run(O_LBU, 32'h103, 32'h0, 1, mk_mem(32'h100, 4'h8, 0, 0, 0, 0, 32'h80112233, 1),
        mk_done(3, 0, 0, 0, 32'h00000080));
    run(O_SH,  32'h202, 32'h0000ABCD, 1, mk_mem(32'h200, 4'hC, 1, 32'hABCDABCD, 0, 0, 0, 1),
        mk_done(2, 0, 0, 0, 32'h00000080));
    run(O_LW,  32'h102, 32'h0, 0, nomem, mk_done(1, 1, 0, 0, 32'h00000080));
    run(O_SH,  32'h201, 32'h1234, 0, nomem, mk_done(1, 0, 1, 0, 32'h00000080));
    run(O_LW,  32'h300, 32'h0, 1, mk_mem(32'h300, 4'hF, 0, 0, 0, 1, 0, 4),
        mk_done(5, 0, 0, 1, 32'h00000080));
    run(O_LH,  32'h106, 32'h0, 1, mk_mem(32'h104, 4'hC, 0, 0, 2, 0, 32'h80011234, 3),
        mk_done(5, 0, 0, 0, 32'hFFFF8001));
    run(O_LHU, 32'h102, 32'h0, 1, mk_mem(32'h100, 4'hC, 0, 0, 0, 0, 32'h80011234, 1),
        mk_done(3, 0, 0, 0, 32'h00008001));
    run(O_SB,  32'h205, 32'h000000A5, 1, mk_mem(32'h204, 4'h2, 1, 32'hA5A5A5A5, 0, 0, 0, 1),
        mk_done(2, 0, 0, 0, 32'h00008001));
    run(O_SW,  32'h208, 32'h12345678, 1, mk_mem(32'h208, 4'hF, 1, 32'h12345678, 1, 0, 0, 2),
        mk_done(3, 0, 0, 0, 32'h00008001));
    // ack on the same cycle the timeout would fire
    run(O_LW,  32'h30C, 32'h0, 1, mk_mem(32'h30C, 4'hF, 0, 0, 3, 0, 32'h55AA55AA, 4),
        mk_done(6, 0, 0, 0, 32'h55AA55AA));

    // non-memory opcode is ignored
    issue(6'h00, 32'h100, 32'h0);
    @(negedge clk);
    chk("nonmem_busy", 32'(busy), 32'd0);
    chk("nonmem_req", 32'(mem_if.mem_req), 32'd0);

    // reset during the third request cycle
    mq.push_back(mk_mem(32'h400, 4'hF, 0, 0, 0, 1, 0, 3));
    issue(O_LW, 32'h400, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_req", 32'(mem_if.mem_req), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    chk("rst_mid_ld", ld_data, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run(O_LW,  32'h104, 32'h0, 1, mk_mem(32'h104, 4'hF, 0, 0, 0, 0, 32'hCAFEF00D, 1),
        mk_done(3, 0, 0, 0, 32'hCAFEF00D));

    repeat (5) @(negedge clk);
    chk("mem_queue_empty", 32'(mq.size()), 32'd0);
    chk("done_queue_empty", 32'(dq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
